alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU between the BR/ACC datapath and the control unit.
// A one-cycle start launches an operation on operands latched at accept.
// Single-cycle ops take one execute cycle; MPY runs an iterative signed
// shift-add multiplier for WIDTH cycles before its execute cycle.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset
//   start     - launch request, honoured only while busy is low
//   op        - operation code (0..9 legal, 10..15 flagged ERR)
//   a, b      - signed operands (a = ACC side, b = BR side)
//   busy      - operation in flight
//   done      - one-cycle completion pulse
//   result    - low result word (to ACC)
//   result_hi - high product word (to MR), zero for non-MPY ops
//   flags     - {ERR, 3'b000, V, C, Z, N}
`timescale 1ns/1ps
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        result,
  output logic [WIDTH-1:0]        result_hi,
  output logic [7:0]              flags
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SLA = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MPY = 4'd9;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  // Control state (reset)
  state_t           state_q, state_d;
  logic             launch_q, launch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [7:0]       flags_q, flags_d;

  // Operand and multiplier datapath (not reset)
  logic [3:0]              op_q, op_d;
  logic signed [WIDTH-1:0] a_q, a_d;
  logic signed [WIDTH-1:0] b_q, b_d;
  logic signed [WIDTH-1:0] mh_q, mh_d;
  logic [WIDTH-1:0]        ml_q, ml_d;

  logic             busy_int;
  logic             accept;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] alu_hi;
  logic             fl_n, fl_z, fl_c, fl_v, fl_err;

  function automatic logic [7:0] pack_flags(input logic err, input logic v,
                                            input logic c, input logic z,
                                            input logic n);
    return {err, 3'b000, v, c, z, n};
  endfunction

  // launch_q marks the cycle after accept: operands are captured and the
  // op is decoded before entering EXEC or MUL.
  assign busy_int = launch_q || (state_q == EXEC) || (state_q == MUL);
  assign accept   = start && !busy_int;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      launch_q    <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      launch_q    <= launch_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
    mh_q <= mh_d;
    ml_q <= ml_d;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    launch_d = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (launch_q) begin
          state_d = (op_q == OP_MPY) ? MUL : EXEC;
          cnt_d   = '0;
        end
      end
      EXEC: state_d = DONE;
      MUL: begin
        cnt_d = cnt_q + 1'b1;
        // The product is finished after the last iteration; EXEC then
        // derives the flags from it like any other op.
        if (cnt_q == CNT_LAST) begin
          state_d = EXEC;
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      launch_d = 1'b1;
    end
  end

  // Operand capture and shift-add multiplier: {mh, ml} starts as {0, b};
  // each step adds a when the low bit is set (subtracts on the sign bit's
  // step, which carries negative weight) and shifts right arithmetically.
  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    mh_d    = mh_q;
    ml_d    = ml_q;
    mul_sum = {mh_q[WIDTH-1], mh_q};
    if (ml_q[0]) begin
      if (cnt_q == CNT_LAST) begin
        mul_sum = {mh_q[WIDTH-1], mh_q} - {a_q[WIDTH-1], a_q};
      end else begin
        mul_sum = {mh_q[WIDTH-1], mh_q} + {a_q[WIDTH-1], a_q};
      end
    end
    if (accept) begin
      op_d = op;
      a_d  = a;
      b_d  = b;
      mh_d = '0;
      ml_d = b;
    end else if (state_q == MUL) begin
      mh_d = mul_sum[WIDTH:1];
      ml_d = {mul_sum[0], ml_q[WIDTH-1:1]};
    end
  end

  // Output logic: result evaluation and commit at the EXEC -> DONE edge
  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    add_sum = '0;
    fl_c    = 1'b0;
    fl_v    = 1'b0;
    fl_err  = 1'b0;
    case (op_q)
      OP_ADD: begin
        add_sum = {1'b0, a_q} + {1'b0, b_q};
        alu_res = add_sum[WIDTH-1:0];
        fl_c    = add_sum[WIDTH];
        fl_v    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the unsigned borrow.
        add_sum = {1'b0, a_q} - {1'b0, b_q};
        alu_res = add_sum[WIDTH-1:0];
        fl_c    = add_sum[WIDTH];
        fl_v    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SLL: begin
        alu_res = {a_q[WIDTH-2:0], 1'b0};
        fl_c    = a_q[WIDTH-1];
      end
      OP_SRL: begin
        alu_res = {1'b0, a_q[WIDTH-1:1]};
        fl_c    = a_q[0];
      end
      OP_SLA: begin
        alu_res = {a_q[WIDTH-2:0], 1'b0};
        fl_c    = a_q[WIDTH-1];
        fl_v    = a_q[WIDTH-1] ^ a_q[WIDTH-2];
      end
      OP_SRA: begin
        alu_res = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        fl_c    = a_q[0];
      end
      OP_MPY: begin
        alu_res = ml_q;
        alu_hi  = mh_q;
        // Fits in WIDTH bits only if the high word is pure sign extension.
        fl_v    = (mh_q != {WIDTH{ml_q[WIDTH-1]}});
      end
      default: fl_err = 1'b1;
    endcase
    // alu_hi is zero outside MPY, so this is result==0 there and the full
    // product test for MPY.
    fl_z = (alu_res == '0) && (alu_hi == '0) && !fl_err;
    fl_n = alu_res[WIDTH-1];

    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    if (state_q == EXEC) begin
      result_d    = alu_res;
      result_hi_d = alu_hi;
      flags_d     = pack_flags(fl_err, fl_v, fl_c, fl_z, fl_n);
    end

    busy      = busy_int;
    done      = (state_q == DONE);
    result    = result_q;
    result_hi = result_hi_q;
    flags     = flags_q;
  end

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int W = 16;

  logic                clk;
  logic                rst;
  logic                start;
  logic [3:0]          op;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic                busy;
  logic                done;
  logic [W-1:0]        result;
  logic [W-1:0]        result_hi;
  logic [7:0]          flags;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  task automatic model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] r, output logic [15:0] h, output logic [7:0] f);
    int     sx, sy, ux, uy, s;
    longint p;
    bit     n, z, c, v, e;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'({16'h0000, x});
    uy = int'({16'h0000, y});
    p = 0; r = '0; h = '0; c = 0; v = 0; e = 0;
    case (o)
      4'd0: begin
        s = ux + uy; r = 16'(s); c = (s > 65535);
        v = (sx + sy > 32767) || (sx + sy < -32768);
      end
      4'd1: begin
        s = ux - uy; r = 16'(s); c = (ux < uy);
        v = (sx - sy > 32767) || (sx - sy < -32768);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = ~x;
      4'd5: begin r = 16'(ux * 2); c = x[15]; end
      4'd6: begin r = 16'(ux / 2); c = x[0]; end
      4'd7: begin
        r = 16'(ux * 2); c = x[15];
        v = (sx * 2 > 32767) || (sx * 2 < -32768);
      end
      4'd8: begin r = 16'(sx >>> 1); c = x[0]; end
      4'd9: begin
        p = longint'(sx) * longint'(sy);
        r = 16'(p); h = 16'(p >>> 16);
        v = (p > 32767) || (p < -32768);
      end
      default: e = 1;
    endcase
    if (e) z = 0;
    else if (o == 4'd9) z = (p == 0);
    else z = (r == 16'h0000);
    n = r[15];
    f = {e, 3'b000, v, c, z, n};
  endtask

  // Issues one op from the current (between-edge) time, scrambles the input
  // bus after accept, and checks latency, busy/done behaviour and outputs.
  task automatic run_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                        input bit poke);
    logic [15:0] er, eh;
    logic [7:0]  ef;
    int          lat, exp_lat, busy_lo;
    model(o, x, y, er, eh, ef);
    exp_lat = (o == 4'd9) ? W + 2 : 2;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    check("accept_busy_done", {busy, done}, 2'b10);
    start = 1'b0; op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    lat = 0; busy_lo = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_lo++;
      if (poke && i == 4) begin start = 1'b1; op = 4'd0; end
      if (poke && i == 5) start = 1'b0;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_gap", 64'(busy_lo), 64'd0);
    check("busy_at_done", {busy, done}, 2'b01);
    check("result", result, er);
    check("result_hi", result_hi, eh);
    check("flags", flags, ef);
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] corners [6];
    corners = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h0001, 16'h8001};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_done;
    rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_result_hi", result_hi, 16'h0000);
    check("rst_flags", flags, 8'h00);
    #10 rst = 1'b1;
    #4;

    run_op(4'd0, 16'h7FFF, 16'h0001, 0);
    run_op(4'd1, 16'h0003, 16'h0005, 0);
    run_op(4'd1, 16'h0005, 16'h0005, 0);
    run_op(4'd9, 16'hFFFD, 16'h0007, 0);
    run_op(4'd9, 16'h4000, 16'h0004, 0);
    run_op(4'd9, 16'h0000, 16'h1234, 0);
    run_op(4'd8, 16'h8001, 16'h0000, 0);
    run_op(4'd6, 16'h8001, 16'h0000, 0);
    run_op(4'd7, 16'h4000, 16'h0000, 0);
    run_op(4'd12, 16'h1234, 16'h5678, 0);
    // back-to-back: issued in the cycle where done is high
    run_op(4'd0, 16'h1111, 16'h2222, 0);
    run_op(4'd0, 16'hFFFF, 16'h0001, 0);

    // start pulsed mid-MPY must not launch anything
    run_op(4'd9, 16'h0123, 16'hFF00, 1);
    @(posedge clk); #1;
    check("after_poke", {busy, done}, 2'b00);
    @(posedge clk); #1;
    check("after_poke2", {busy, done}, 2'b00);

    // reset in the middle of a multiply
    run_op(4'd3, 16'h00F0, 16'h0F00, 0);
    start = 1'b1; op = 4'd9; a = 16'h0F0F; b = 16'h00FF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_busy_done", {busy, done}, 2'b00);
    check("midrst_result", {result, result_hi}, 32'h0);
    check("midrst_flags", flags, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    check("midrst_no_done", 64'(n_done), 64'd0);

    for (int i = 0; i < 300; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
